// File: rtl/frame_pkg.sv
// frame_pkg: definitions shared by the frame readout path and the
// median-filter datapath that writes the frame buffer.
//   state_t      : readout FSM encoding (IDLE, READ, DRAIN)
//   DEF_*        : default frame geometry and bus widths, defined once here
//   ptr_inc      : modulo-3 pointer increment for the 3-entry return FIFO
package frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int DEF_WIDTH  = 640;
    localparam int DEF_HEIGHT = 480;
    localparam int DEF_ADDR_W = 19;
    localparam int DEF_PIX_W  = 8;

    // The return FIFO has three slots, so its pointers wrap 2 -> 0.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/pixel_fifo3.sv
// pixel_fifo3: 3-entry synchronous FIFO holding returned pixels with their
// sof/eol tags.
//   clk, rst        : clock, asynchronous active-low reset
//   push, push_data : write one entry (caller guarantees not full)
//   pop             : remove the head entry (ignored when empty)
//   occ             : number of stored entries, 0..3
//   empty           : occ == 0
//   head            : oldest entry, stable until popped
module pixel_fifo3
    import frame_pkg::*;
#(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [W-1:0] mem [0:2];
    logic [1:0]   wr_ptr;
    logic [1:0]   rd_ptr;
    logic         pop_ok;

    assign empty  = (occ == 2'd0);
    assign pop_ok = pop && !empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            // Push and pop in the same cycle leave occ unchanged.
            occ <= occ + {1'b0, push} - {1'b0, pop_ok};
        end
    end

endmodule

// File: rtl/frame_readout.sv
// frame_readout: raster-order reader of the filtered frame buffer.
// Walks addresses 0..WIDTH*HEIGHT-1 of a 1-cycle-latency RAM and presents
// the pixels as a valid/ready stream tagged with start-of-frame / end-of-line.
//   clk, rst        : clock, asynchronous active-low reset
//   start           : one-cycle frame request, honoured only in IDLE
//   rd_en, rd_addr  : RAM read strobe and address
//   rd_data         : RAM data, valid the cycle after rd_en
//   pix_data/valid  : output stream pixel and valid
//   pix_ready       : sink ready
//   pix_sof/pix_eol : tags for address 0 and for x == WIDTH-1
//   busy            : high outside IDLE
//   frame_done      : pulse on the handshake of the last pixel
//   dbg_state       : current FSM state
//
// Stream handshake: a pixel transfers on a rising edge where pix_valid and
// pix_ready are both high; while pix_valid is high and pix_ready is low the
// pixel and its tags hold steady. pix_valid never depends on pix_ready.
module frame_readout
    import frame_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int PIX_W  = DEF_PIX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic [PIX_W-1:0]  pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_sof,
    output logic              pix_eol,
    output logic              busy,
    output logic              frame_done,
    output state_t            dbg_state
);

    localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int FW = PIX_W + 2;

    state_t state, state_nx;

    logic [ADDR_W-1:0] addr;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic              x_last;
    logic              last_pix;

    logic              inflight;
    logic              sof_q;
    logic              eol_q;

    logic [1:0]        occ;
    logic              empty;
    logic [FW-1:0]     head;
    logic              pop;
    logic              credit_ok;
    logic              last_hs;

    assign x_last   = (x == XW'(WIDTH - 1));
    assign last_pix = x_last && (y == YW'(HEIGHT - 1));

    // Credits count stored entries plus the read still on its way back, so
    // a full FIFO can always absorb the returning word. Only registered
    // terms appear here: pix_ready has no path to rd_en.
    assign credit_ok = ({1'b0, occ} + {2'b00, inflight}) < 3'd3;

    assign pop     = !empty && pix_ready;
    // Final handshake: one entry left and nothing still returning.
    assign last_hs = pop && (occ == 2'd1) && !inflight;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  if (start)              state_nx = ST_READ;
            ST_READ:  if (rd_en && last_pix)  state_nx = ST_DRAIN;
            ST_DRAIN: if (last_hs)            state_nx = ST_IDLE;
            default:                          state_nx = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy       = 1'b0;
        rd_en      = 1'b0;
        frame_done = 1'b0;
        case (state)
            ST_READ: begin
                busy  = 1'b1;
                rd_en = credit_ok;
            end
            ST_DRAIN: begin
                busy       = 1'b1;
                frame_done = last_hs;
            end
            default: ;
        endcase
    end

    assign dbg_state = state;

    // ---------------- address / raster counters ----------------
    // Counters rewind to 0 on the last issue so each frame starts clean.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr <= '0;
            x    <= '0;
            y    <= '0;
        end else if (rd_en) begin
            if (last_pix) begin
                addr <= '0;
                x    <= '0;
                y    <= '0;
            end else begin
                addr <= addr + ADDR_W'(1);
                if (x_last) begin
                    x <= '0;
                    y <= y + YW'(1);
                end else begin
                    x <= x + XW'(1);
                end
            end
        end
    end

    assign rd_addr = addr;

    // ---------------- flag pipeline ----------------
    // Tags are decided at issue and travel with the read so they line up
    // with rd_data one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight <= 1'b0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                sof_q <= (addr == '0);
                eol_q <= x_last;
            end
        end
    end

    pixel_fifo3 #(
        .W (FW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data ({rd_data, sof_q, eol_q}),
        .pop       (pop),
        .occ       (occ),
        .empty     (empty),
        .head      (head)
    );

    // Outputs read zero whenever nothing is valid, including right after reset.
    assign pix_valid = !empty;
    assign pix_data  = pix_valid ? head[FW-1:2] : '0;
    assign pix_sof   = pix_valid && head[1];
    assign pix_eol   = pix_valid && head[0];

endmodule

// File: doc/frame_readout.md
# frame_readout

Raster-order reader for the 8-bit filtered-image frame buffer that the median-filter datapath fills one pixel per address. On `start`, it walks addresses 0..WIDTH*HEIGHT-1 against a synchronous RAM with 1-cycle read latency. It delivers the pixels as a valid/ready stream tagged with start-of-frame and end-of-line, for the display or host-link side. It is the read end of the filter's pixel/address write interface.

## Interface
- `WIDTH`, default 640: pixels per line.
- `HEIGHT`, default 480: lines per frame.
- `ADDR_W`, default 19: RAM address width; WIDTH*HEIGHT must not exceed 2^ADDR_W.
- `PIX_W`, default 8: pixel width.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to read one frame; honoured only in IDLE.
- `rd_en` out 1: RAM read strobe.
- `rd_addr` out ADDR_W: RAM read address.
- `rd_data` in PIX_W: RAM data, valid the cycle after `rd_en`.
- `pix_data` out PIX_W: stream pixel.
- `pix_valid` out 1: stream valid.
- `pix_ready` in 1: sink ready.
- `pix_sof` out 1: qualifies the pixel at address 0.
- `pix_eol` out 1: qualifies the pixel with x == WIDTH-1.
- `busy` out 1: high from READ entry until the last handshake completes.
- `frame_done` out 1: one-cycle pulse on the last pixel's handshake.

## Operation
- FSM states:
  - IDLE: `start` -> READ.
  - READ: last address issued -> DRAIN.
  - DRAIN: last pixel handshake -> IDLE, with `frame_done` = 1 in that same cycle.
- `busy` = (state != IDLE).
- Read issue: `rd_en` = (state == READ) && (occ + inflight < 3).
  - occ is the FIFO occupancy (0..3), registered.
  - inflight is 1 if `rd_en` was high last cycle, registered.
- There is no combinational path from `pix_ready` to `rd_en`.
- Address counter:
  - Increments on each `rd_en`.
  - x counter wraps at WIDTH-1; y counter increments on that wrap.
  - sof and eol flags are computed at issue and pipelined alongside the read.
- Return capture: the cycle after `rd_en`, {`rd_data`, sof, eol} is pushed into a 3-entry FIFO.
  - The credit rule guarantees the FIFO never overflows, so no push is ever dropped.
- Stream side:
  - `pix_valid` = FIFO not empty; the head drives `pix_data`, `pix_sof`, `pix_eol`.
  - Pop on `pix_valid && pix_ready`.
  - Head fields are stable while `pix_valid && !pix_ready`.
- Simultaneous push and pop: occ is unchanged and ordering is preserved.
- `start` while busy: ignored, with no effect on counters.
- Reset: asynchronous.
  - FSM returns to IDLE; counters, credits and FIFO are cleared.
  - A RAM read in flight when reset asserts is discarded.
- Reset values: `rd_en` 0, `rd_addr` 0, `pix_data` 0, `pix_valid` 0, `pix_sof` 0, `pix_eol` 0, `busy` 0, `frame_done` 0.

## Timing
- Let edge E0 sample `start`=1 in IDLE.
- Cycle after E0: `busy`=1, `rd_en`=1, `rd_addr`=0.
- Cycle after E1: `rd_data` for address 0 is present.
- Cycle after E2: `pix_valid`=1 and `pix_sof`=1. Start-to-first-valid latency is 3 edges.
- Throughput with `pix_ready` held high: 1 pixel/cycle, with no bubbles after the first pixel.
- Full frame with `pix_ready` high: WIDTH*HEIGHT+2 cycles from E0 to the `frame_done` cycle.
- Sink stall:
  - `rd_en` drops once occ + inflight = 3.
  - It resumes the cycle after a pop frees a slot.
- Back-to-back frames:
  - A `start` sampled in the cycle after `frame_done` begins the next frame.
  - A `start` in the `frame_done` cycle itself is ignored, because the FSM is still in DRAIN.

## Structure
- Shared package `frame_pkg` holds:
  - FSM state encoding (IDLE, READ, DRAIN).
  - Default WIDTH, HEIGHT, ADDR_W and PIX_W constants, shared with the median-filter datapath so frame geometry is defined once.
- Sub-module `pixel_fifo3`:
  - 3-entry synchronous FIFO of width PIX_W+2.
  - Exposes push, pop, occ, empty and head.
  - Uses the same asynchronous active-low reset.
- The top level contains the FSM, the address/x/y counters, the credit logic and the flag pipeline.

## Test plan
- Full frame, ready high: WIDTH=4, HEIGHT=3, RAM[i]=i.
  - Stream is 0..11 on consecutive cycles.
  - `pix_sof` is set only on 0; `pix_eol` is set on 3, 7 and 11.
  - `frame_done` fires 14 cycles after E0.
- Random backpressure at ~50% ready:
  - Data order and flags are unchanged.
  - Head is stable during stalls.
  - `rd_en` is never high with occ + inflight = 3, and no FIFO overflow occurs.
- Ready held low for 20 cycles after the first valid:
  - Exactly 3 reads are issued, then `rd_en` stays 0.
  - On release, pixels 0,1,2,3... stream with no loss.
- `start` pulsed at cycles 2, 5 and 9 of a busy frame: no restart and no address jump; a single `frame_done` pulse.
- `rst` asserted mid-frame with occ=2 and a read in flight:
  - All outputs read 0 immediately.
  - After release and a new `start`, the stream begins at address 0 with `pix_sof`=1.
- Back-to-back frames: `start` in the cycle after `frame_done` yields a second identical frame.
